// File: rtl/lab4d_pkg.sv
// Shared constants, state encoding and buffer address layout for the LAB4D readout engine.
package lab4d_pkg;

  localparam int unsigned LAB4D_BITS          = 12;
  localparam int unsigned LAB4D_SAMPLES       = 128;
  localparam int unsigned LAB4D_WINDOW_BITS   = 6;
  localparam int unsigned LAB4D_SAMPLE_BITS   = 7;
  localparam int unsigned LAB4D_BITCNT_BITS   = 4;
  localparam int unsigned LAB4D_PRESCALE_BITS = 4;
  localparam int unsigned LAB4D_ADR_BITS      = LAB4D_WINDOW_BITS + LAB4D_SAMPLE_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SSRST,
    ST_SHI,
    ST_SLO,
    ST_WRITE,
    ST_INCR,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [LAB4D_WINDOW_BITS-1:0] window;
    logic [LAB4D_SAMPLE_BITS-1:0] sample;
  } buf_adr_t;

  // States whose length is set by the prescaler (H cycles each).
  function automatic logic is_phase_state(state_e s);
    return (s == ST_SSRST) || (s == ST_SHI) || (s == ST_SLO) || (s == ST_INCR);
  endfunction

endpackage

// File: rtl/lab4d_readout_prescaler.sv
// Load/terminal-count down-counter; phase_end_c marks the last cycle of an H-cycle phase.
module lab4d_readout_prescaler
  import lab4d_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           load,
  input  logic [LAB4D_PRESCALE_BITS-1:0] load_value,
  output logic                           phase_end_c
);

  logic [LAB4D_PRESCALE_BITS-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - LAB4D_PRESCALE_BITS'(1);
    end
  end

  assign phase_end_c = (cnt_q == '0);

endmodule

// File: rtl/lab4d_readout_engine.sv
// Readout responder: clocks one window of samples out of all LAB4D chips in parallel
// and writes each sample into the sample buffer, then pulses complete_o.
module lab4d_readout_engine
  import lab4d_pkg::*;
#(
  parameter int unsigned NUM_LAB = 12,
  parameter int unsigned SAMPLES = LAB4D_SAMPLES,
  parameter int unsigned BITS    = LAB4D_BITS
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           readout_i,
  input  logic [LAB4D_WINDOW_BITS-1:0]   readout_address_i,
  input  logic [LAB4D_PRESCALE_BITS-1:0] prescale_i,
  output logic                           complete_o,
  output logic                           busy_o,
  output logic [NUM_LAB-1:0]             SS_RST,
  output logic [NUM_LAB-1:0]             SS_INCR,
  output logic [NUM_LAB-1:0]             SRCLK,
  input  logic [NUM_LAB-1:0]             DOE,
  output logic                           buf_we_o,
  output logic [LAB4D_ADR_BITS-1:0]      buf_adr_o,
  output logic [NUM_LAB*BITS-1:0]        buf_dat_o
);

  localparam int unsigned DAT_W = NUM_LAB * BITS;

  state_e state_q, state_d;

  logic [LAB4D_WINDOW_BITS-1:0]   window_q;
  logic [LAB4D_PRESCALE_BITS-1:0] presc_q;
  logic [LAB4D_BITCNT_BITS-1:0]   bit_cnt_q;
  logic [LAB4D_SAMPLE_BITS-1:0]   sample_q;
  logic [DAT_W-1:0]               shreg_q;
  buf_adr_t                       buf_adr_q;
  logic [DAT_W-1:0]               buf_dat_q;

  logic busy_q, complete_q, ss_rst_q, ss_incr_q, srclk_q, buf_we_q;
  logic busy_d, complete_d, ss_rst_d, ss_incr_d, srclk_d, buf_we_d;

  logic                           phase_end_c;
  logic                           presc_load_c;
  logic [LAB4D_PRESCALE_BITS-1:0] presc_value_c;
  logic                           last_bit_c;
  logic                           last_sample_c;

  assign last_bit_c    = (bit_cnt_q == LAB4D_BITCNT_BITS'(BITS - 1));
  assign last_sample_c = (sample_q == LAB4D_SAMPLE_BITS'(SAMPLES - 1));

  // Reload at every phase boundary and outside timed phases; in IDLE the live
  // prescale_i is loaded so the first SSRST cycle already sees the new value.
  assign presc_load_c  = !is_phase_state(state_q) || phase_end_c;
  assign presc_value_c = (state_q == ST_IDLE) ? prescale_i : presc_q;

  lab4d_readout_prescaler u_prescaler (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load        (presc_load_c),
    .load_value  (presc_value_c),
    .phase_end_c (phase_end_c)
  );

  // Next-state and next-output decode; outputs are registered from state_d.
  always_comb begin
    state_d    = state_q;
    busy_d     = 1'b0;
    complete_d = 1'b0;
    ss_rst_d   = 1'b0;
    ss_incr_d  = 1'b0;
    srclk_d    = 1'b0;
    buf_we_d   = 1'b0;

    case (state_q)
      ST_IDLE:  if (readout_i) state_d = ST_SSRST;
      ST_SSRST: if (phase_end_c) state_d = ST_SHI;
      ST_SHI:   if (phase_end_c) state_d = ST_SLO;
      ST_SLO:   if (phase_end_c) state_d = last_bit_c ? ST_WRITE : ST_SHI;
      ST_WRITE: state_d = last_sample_c ? ST_DONE : ST_INCR;
      ST_INCR:  if (phase_end_c) state_d = ST_SHI;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    complete_d = (state_d == ST_DONE);
    ss_rst_d   = (state_d == ST_SSRST);
    ss_incr_d  = (state_d == ST_INCR);
    srclk_d    = (state_d == ST_SHI);
    buf_we_d   = (state_d == ST_WRITE);
  end

  // State and control-output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      ss_rst_q   <= 1'b0;
      ss_incr_q  <= 1'b0;
      srclk_q    <= 1'b0;
      buf_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      ss_rst_q   <= ss_rst_d;
      ss_incr_q  <= ss_incr_d;
      srclk_q    <= srclk_d;
      buf_we_q   <= buf_we_d;
    end
  end

  // Request latch, bit/sample counters, per-chip shift registers and buffer payload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      window_q  <= '0;
      presc_q   <= '0;
      bit_cnt_q <= '0;
      sample_q  <= '0;
      shreg_q   <= '0;
      buf_adr_q <= '0;
      buf_dat_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (readout_i) begin
            window_q  <= readout_address_i;
            presc_q   <= prescale_i;
            sample_q  <= '0;
            bit_cnt_q <= '0;
          end
        end
        ST_SSRST: begin
          if (phase_end_c) bit_cnt_q <= '0;
        end
        ST_SHI: begin
          if (phase_end_c) begin
            for (int unsigned n = 0; n < NUM_LAB; n++) begin
              shreg_q[n*BITS +: BITS] <= {shreg_q[n*BITS +: BITS-1], DOE[n]};
            end
          end
        end
        ST_SLO: begin
          if (phase_end_c) bit_cnt_q <= bit_cnt_q + LAB4D_BITCNT_BITS'(1);
        end
        ST_WRITE: begin
          bit_cnt_q <= '0;
        end
        ST_INCR: begin
          if (phase_end_c) sample_q <= sample_q + LAB4D_SAMPLE_BITS'(1);
        end
        default: ;
      endcase

      // Payload is captured on entry so it is valid alongside the write strobe.
      if (state_d == ST_WRITE) begin
        buf_adr_q.window <= window_q;
        buf_adr_q.sample <= sample_q;
        buf_dat_q        <= shreg_q;
      end
    end
  end

  assign complete_o = complete_q;
  assign busy_o     = busy_q;
  assign SS_RST     = {NUM_LAB{ss_rst_q}};
  assign SS_INCR    = {NUM_LAB{ss_incr_q}};
  assign SRCLK      = {NUM_LAB{srclk_q}};
  assign buf_we_o   = buf_we_q;
  assign buf_adr_o  = buf_adr_q;
  assign buf_dat_o  = buf_dat_q;

endmodule

// File: tb/tb_lab4d_readout_engine.sv
// Directed bench for lab4d_readout_engine with a small window (SAMPLES=4) and a
// behavioural LAB4D model that presents each chip's pattern MSB first on DOE.
module tb_lab4d_readout_engine;

  localparam int unsigned NL = 12;
  localparam int unsigned S  = 4;
  localparam int unsigned B  = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              readout = 1'b0;
  logic [5:0]        addr = '0;
  logic [3:0]        presc = '0;
  logic              complete_o, busy_o, buf_we_o;
  logic [NL-1:0]     ss_rst, ss_incr, srclk, doe;
  logic [12:0]       buf_adr_o;
  logic [NL*B-1:0]   buf_dat_o;

  int checks = 0;
  int errors = 0;

  logic [11:0] pat [NL];
  int          bit_idx = 0;
  logic        prev_hi = 1'b0;

  logic [12:0]     wr_adr [$];
  logic [NL*B-1:0] wr_dat [$];
  int   n_complete = 0, incr_after = 0, done_after = 0;
  logic prev_we = 1'b0;
  int   hi_run = 0, lo_run = 0, hi_cnt = 0, lo_cnt = 0;
  int   hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
  logic seen_hi = 1'b0, lo_clean = 1'b0;

  lab4d_readout_engine #(.NUM_LAB(NL), .SAMPLES(S), .BITS(B)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .readout_i         (readout),
    .readout_address_i (addr),
    .prescale_i        (presc),
    .complete_o        (complete_o),
    .busy_o            (busy_o),
    .SS_RST            (ss_rst),
    .SS_INCR           (ss_incr),
    .SRCLK             (srclk),
    .DOE               (doe),
    .buf_we_o          (buf_we_o),
    .buf_adr_o         (buf_adr_o),
    .buf_dat_o         (buf_dat_o)
  );

  always #5 clk = ~clk;

  function automatic logic doe_bit(logic [11:0] p, int idx);
    if (idx >= 0 && idx < 12) return p[11-idx];
    return 1'b0;
  endfunction

  always_comb begin
    for (int n = 0; n < NL; n++) doe[n] = doe_bit(pat[n], bit_idx);
  end

  // Chip model bit pointer, write capture and SRCLK phase statistics.
  always @(negedge clk) begin
    if (rst || ss_rst[0] || ss_incr[0]) bit_idx = 0;
    else if (prev_hi && !srclk[0]) bit_idx = bit_idx + 1;

    if (buf_we_o) begin
      wr_adr.push_back(buf_adr_o);
      wr_dat.push_back(buf_dat_o);
    end
    if (complete_o) n_complete++;
    if (prev_we && ss_incr[0]) incr_after++;
    if (prev_we && complete_o) done_after++;
    prev_we = buf_we_o;

    if (srclk[0]) begin
      if (!prev_hi) begin
        if (seen_hi && lo_clean) begin
          lo_cnt++;
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        hi_run = 1;
      end else begin
        hi_run++;
      end
      seen_hi = 1'b1;
    end else begin
      if (prev_hi) begin
        hi_cnt++;
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_run   = 1;
        lo_clean = !buf_we_o;
      end else begin
        lo_run++;
        if (buf_we_o) lo_clean = 1'b0;
      end
    end
    prev_hi = srclk[0];
  end

  task automatic clear_mon();
    wr_adr.delete();
    wr_dat.delete();
    n_complete = 0; incr_after = 0; done_after = 0;
    hi_cnt = 0; lo_cnt = 0; hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    seen_hi = 1'b0;
  endtask

  task automatic set_pat_all(logic [11:0] v);
    for (int n = 0; n < NL; n++) pat[n] = v;
  endtask

  // Request sampled at the next edge (k); returns at the negedge of cycle k+1.
  task automatic start_readout(logic [5:0] a, logic [3:0] p);
    @(negedge clk);
    addr = a; presc = p; readout = 1'b1;
    @(negedge clk);
    readout = 1'b0;
  endtask

  task automatic wait_complete(output int n);
    n = 1;
    while (!complete_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic idle_cycles(int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(2);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (complete_o !== 1'b0) begin errors++; $display("FAIL reset_complete got %b want 0", complete_o); end
    checks++; if (ss_rst !== '0) begin errors++; $display("FAIL reset_ss_rst got %h want 0", ss_rst); end
    checks++; if (ss_incr !== '0) begin errors++; $display("FAIL reset_ss_incr got %h want 0", ss_incr); end
    checks++; if (srclk !== '0) begin errors++; $display("FAIL reset_srclk got %h want 0", srclk); end
    checks++; if (buf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", buf_we_o); end
    checks++; if (buf_adr_o !== 13'h0) begin errors++; $display("FAIL reset_adr got %h want 0", buf_adr_o); end
    checks++; if (buf_dat_o !== '0) begin errors++; $display("FAIL reset_dat got %h want 0", buf_dat_o); end
    rst = 1'b0;
    idle_cycles(2);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy_o); end
  endtask

  task automatic test_basic();
    int n;
    logic [NL*B-1:0] exp_dat;
    exp_dat = {NL{12'hA5C}};
    set_pat_all(12'hA5C);
    clear_mon();
    start_readout(6'h15, 4'd0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy_o); end
    wait_complete(n);
    checks++; if (n != 105) begin errors++; $display("FAIL basic_complete_cycle got %0d want 105", n); end
    idle_cycles(4);
    checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL basic_write_count got %0d want 4", wr_adr.size()); end
    for (int i = 0; i < wr_adr.size() && i < 4; i++) begin
      checks++;
      if (wr_adr[i] !== 13'hA80 + 13'(i)) begin errors++; $display("FAIL basic_adr%0d got %h want %h", i, wr_adr[i], 13'hA80 + 13'(i)); end
      checks++;
      if (wr_dat[i] !== exp_dat) begin errors++; $display("FAIL basic_dat%0d got %h want %h", i, wr_dat[i], exp_dat); end
    end
    checks++; if (n_complete != 1) begin errors++; $display("FAIL basic_complete_count got %0d want 1", n_complete); end
    checks++; if (incr_after != 3) begin errors++; $display("FAIL basic_incr_after_we got %0d want 3", incr_after); end
    checks++; if (done_after != 1) begin errors++; $display("FAIL basic_done_after_we got %0d want 1", done_after); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy_o); end
  endtask

  task automatic test_prescale();
    int n;
    set_pat_all(12'h3C6);
    clear_mon();
    start_readout(6'h2A, 4'd3);
    presc = 4'd0;
    wait_complete(n);
    checks++; if (n != 405) begin errors++; $display("FAIL presc_complete_cycle got %0d want 405", n); end
    idle_cycles(4);
    checks++; if (hi_cnt != 48) begin errors++; $display("FAIL presc_hi_count got %0d want 48", hi_cnt); end
    checks++; if (hi_min != 4 || hi_max != 4) begin errors++; $display("FAIL presc_hi_len got %0d..%0d want 4..4", hi_min, hi_max); end
    checks++; if (lo_cnt != 44) begin errors++; $display("FAIL presc_lo_count got %0d want 44", lo_cnt); end
    checks++; if (lo_min != 4 || lo_max != 4) begin errors++; $display("FAIL presc_lo_len got %0d..%0d want 4..4", lo_min, lo_max); end
    checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL presc_write_count got %0d want 4", wr_adr.size()); end
    else begin
      checks++; if (wr_adr[3] !== 13'h1503) begin errors++; $display("FAIL presc_last_adr got %h want 1503", wr_adr[3]); end
      checks++; if (wr_dat[3] !== {NL{12'h3C6}}) begin errors++; $display("FAIL presc_last_dat got %h want %h", wr_dat[3], {NL{12'h3C6}}); end
    end
  endtask

  task automatic test_per_chip();
    int n;
    logic [NL*B-1:0] exp_dat;
    for (int c = 0; c < NL; c++) begin
      pat[c] = 12'(c * 12'h111);
      exp_dat[c*B +: B] = 12'(c * 12'h111);
    end
    clear_mon();
    start_readout(6'h3F, 4'd1);
    wait_complete(n);
    checks++; if (n != 205) begin errors++; $display("FAIL chip_complete_cycle got %0d want 205", n); end
    idle_cycles(4);
    checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL chip_write_count got %0d want 4", wr_adr.size()); end
    else begin
      for (int c = 0; c < NL; c++) begin
        checks++;
        if (wr_dat[0][c*B +: B] !== 12'(c * 12'h111)) begin
          errors++; $display("FAIL chip%0d_field got %h want %h", c, wr_dat[0][c*B +: B], 12'(c * 12'h111));
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (wr_dat[i] !== exp_dat) begin errors++; $display("FAIL chip_dat%0d got %h want %h", i, wr_dat[i], exp_dat); end
      end
      checks++; if (wr_adr[3] !== 13'h1F83) begin errors++; $display("FAIL chip_last_adr got %h want 1f83", wr_adr[3]); end
    end
  endtask

  task automatic test_request_while_busy();
    int n;
    set_pat_all(12'h0F1);
    clear_mon();
    start_readout(6'h01, 4'd0);
    n = 1;
    while (!complete_o && n < 5000) begin
      @(negedge clk);
      n++;
      readout = (n == 30 || n == 70);
    end
    readout = 1'b0;
    checks++; if (n != 105) begin errors++; $display("FAIL busyreq_complete_cycle got %0d want 105", n); end
    idle_cycles(10);
    checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL busyreq_write_count got %0d want 4", wr_adr.size()); end
    checks++; if (n_complete != 1) begin errors++; $display("FAIL busyreq_complete_count got %0d want 1", n_complete); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL busyreq_busy_end got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    int n, guard, nw;
    set_pat_all(12'h5A3);
    clear_mon();
    start_readout(6'h0A, 4'd0);
    guard = 0;
    while (wr_adr.size() < 2 && guard < 2000) begin @(negedge clk); guard++; end
    checks++; if (wr_adr.size() != 2) begin errors++; $display("FAIL rstmid_reach_sample2 got %0d want 2", wr_adr.size()); end
    idle_cycles(5);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, complete_o, buf_we_o, ss_rst, ss_incr, srclk} !== '0) begin
      errors++; $display("FAIL rstmid_ctrl_zero got %b want 0", {busy_o, complete_o, buf_we_o, ss_rst, ss_incr, srclk});
    end
    checks++;
    if ({buf_adr_o, buf_dat_o} !== '0) begin errors++; $display("FAIL rstmid_data_zero got %h want 0", {buf_adr_o, buf_dat_o}); end
    nw = wr_adr.size();
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(20);
    checks++; if (wr_adr.size() != nw) begin errors++; $display("FAIL rstmid_no_writes got %0d want %0d", wr_adr.size(), nw); end
    checks++; if (n_complete != 0) begin errors++; $display("FAIL rstmid_no_complete got %0d want 0", n_complete); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    clear_mon();
    start_readout(6'h0A, 4'd0);
    wait_complete(n);
    checks++; if (n != 105) begin errors++; $display("FAIL rstmid_restart_cycle got %0d want 105", n); end
    idle_cycles(4);
    checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL rstmid_restart_writes got %0d want 4", wr_adr.size()); end
    else begin
      checks++; if (wr_adr[0] !== 13'h500) begin errors++; $display("FAIL rstmid_restart_adr got %h want 500", wr_adr[0]); end
      checks++; if (wr_dat[0] !== {NL{12'h5A3}}) begin errors++; $display("FAIL rstmid_restart_dat got %h want %h", wr_dat[0], {NL{12'h5A3}}); end
    end
  endtask

  task automatic test_back_to_back();
    int n, m;
    set_pat_all(12'hA5C);
    clear_mon();
    @(negedge clk);
    addr = 6'h07; presc = 4'd0; readout = 1'b1;
    @(negedge clk);
    wait_complete(n);
    checks++; if (n != 105) begin errors++; $display("FAIL b2b_first_cycle got %0d want 105", n); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got %b want 0", busy_o); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", busy_o); end
    readout = 1'b0;
    m = 2;
    while (!complete_o && m < 5000) begin @(negedge clk); m++; end
    checks++; if (m != 106) begin errors++; $display("FAIL b2b_second_cycle got %0d want 106", m); end
    idle_cycles(10);
    checks++; if (wr_adr.size() != 8) begin errors++; $display("FAIL b2b_write_count got %0d want 8", wr_adr.size()); end
    else begin
      checks++; if (wr_adr[4] !== 13'h380) begin errors++; $display("FAIL b2b_second_adr got %h want 380", wr_adr[4]); end
    end
    checks++; if (n_complete != 2) begin errors++; $display("FAIL b2b_complete_count got %0d want 2", n_complete); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy_o); end
  endtask

  initial begin
    set_pat_all(12'h000);
    test_reset();
    test_basic();
    test_prescale();
    test_per_chip();
    test_request_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
